// File: rtl/sid_write_sequencer.sv
// Command-stream sequencer for the SID register write bus: buffers host commands
// in a FIFO and replays writes, timed waits and full-register clears with fixed spacing.
module sid_write_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int WRITE_GAP  = 4,
  parameter int NUM_REGS   = 25
) (
  input  logic                          clk,
  input  logic                          iRstN,
  input  logic                          clkEn,
  input  logic [23:0]                   iCmd,
  input  logic                          iCmdValid,
  output logic                          oCmdReady,
  output logic                          oWE,
  output logic [4:0]                    oAddr,
  output logic [7:0]                    oData,
  output logic                          oBusy,
  output logic [$clog2(FIFO_DEPTH):0]   oLevel,
  output logic                          oDropped
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (WRITE_GAP < 2) ? 1 : $clog2(WRITE_GAP + 1);
  localparam logic [4:0]    LAST_IDX  = 5'(NUM_REGS - 1);
  localparam logic [GW-1:0] GAP_FULL  = GW'(WRITE_GAP);
  localparam logic [GW-1:0] GAP_CLEAR = GW'(WRITE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_GAP,
    S_WAIT,
    S_CLR
  } state_t;

  // Only the opcode and the low 16 argument bits carry meaning; bits [21:16] never do.
  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [LW-1:0] level;
  logic          push;
  logic          pop;
  logic          unusedCmdBits;

  state_t        state;
  logic [1:0]    cmdOp;
  logic [15:0]   cmdArg;
  logic [15:0]   waitCnt;
  logic [GW-1:0] gapCnt;
  logic [4:0]    clrIdx;
  logic          inClr;

  assign unusedCmdBits = ^iCmd[21:16];

  // Valid/ready: a command transfers on any posedge where iCmdValid and oCmdReady
  // are both high; iCmdValid while full is simply ignored.
  assign oCmdReady = iRstN & (level != LW'(FIFO_DEPTH));
  assign push      = iCmdValid & oCmdReady;
  assign pop       = (state == S_IDLE) & (level != '0);
  assign oLevel    = level;
  assign oBusy     = iRstN & ((level != '0) | (state != S_IDLE));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= {iCmd[23:22], iCmd[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!iRstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // CLEAR gaps are one shorter because the CLR cycle itself is a bus-idle clock,
  // so every pulse is still followed by WRITE_GAP idle clocks.
  always_ff @(posedge clk) begin
    if (!iRstN) begin
      state    <= S_IDLE;
      cmdOp    <= '0;
      cmdArg   <= '0;
      waitCnt  <= '0;
      gapCnt   <= '0;
      clrIdx   <= '0;
      inClr    <= 1'b0;
      oWE      <= 1'b0;
      oAddr    <= '0;
      oData    <= '0;
      oDropped <= 1'b0;
    end else begin
      oWE      <= 1'b0;
      oDropped <= 1'b0;
      case (state)
        S_IDLE: begin
          if (level != '0) begin
            cmdOp  <= mem[rdPtr][17:16];
            cmdArg <= mem[rdPtr][15:0];
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cmdOp)
            2'b00: begin
              oAddr  <= cmdArg[12:8];
              oData  <= cmdArg[7:0];
              oWE    <= 1'b1;
              gapCnt <= GAP_FULL;
              state  <= S_GAP;
            end
            2'b01: begin
              waitCnt <= cmdArg;
              state   <= S_WAIT;
            end
            2'b10: begin
              clrIdx <= '0;
              inClr  <= 1'b1;
              state  <= S_CLR;
            end
            default: begin
              oDropped <= 1'b1;
              state    <= S_IDLE;
            end
          endcase
        end
        S_GAP: begin
          if (gapCnt == '0) begin
            state <= inClr ? S_CLR : S_IDLE;
          end else begin
            gapCnt <= gapCnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (waitCnt == '0) begin
            state <= S_IDLE;
          end else if (clkEn) begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        S_CLR: begin
          oAddr <= clrIdx;
          oData <= 8'h00;
          oWE   <= 1'b1;
          state <= S_GAP;
          if (clrIdx == LAST_IDX) begin
            inClr  <= 1'b0;
            gapCnt <= GAP_FULL;
          end else begin
            clrIdx <= clrIdx + 1'b1;
            gapCnt <= GAP_CLEAR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
